// File: rtl/spr_initiator.sv
// SPR bus initiator: takes one mtspr/mfspr request from the pipeline, drives the SPR bus until
// acknowledge, timeout or flush, and returns a single-cycle response pulse.
module spr_initiator #(
  parameter int unsigned OPTION_SPR_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        req_we_i,
  input  logic [15:0] req_addr_i,
  input  logic [31:0] req_dat_i,
  output logic        req_ready_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  input  logic        flush_i,
  output logic        spr_access_o,
  output logic        spr_we_o,
  output logic [15:0] spr_addr_o,
  output logic [31:0] spr_dat_o,
  input  logic        spr_bus_ack_i,
  input  logic [31:0] spr_dat_i
);

  localparam int unsigned CW = $clog2(OPTION_SPR_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(OPTION_SPR_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [15:0]   addr_q;
  logic [31:0]   dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      dat_q     <= '0;
      rsp_dat_o <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            we_q   <= req_we_i;
            addr_q <= req_addr_i;
            dat_q  <= req_dat_i;
            cnt    <= '0;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          // Ack beats both flush and timeout; flush abandons silently.
          if (spr_bus_ack_i) begin
            rsp_dat_o <= we_q ? '0 : spr_dat_i;
            rsp_err_o <= 1'b0;
            state     <= RESP;
          end else if (flush_i) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            rsp_dat_o <= '0;
            rsp_err_o <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state == IDLE);
  assign rsp_valid_o  = (state == RESP);
  assign spr_access_o = (state == ACCESS);
  assign spr_we_o     = spr_access_o & we_q;
  assign spr_addr_o   = spr_access_o ? addr_q : '0;
  assign spr_dat_o    = spr_access_o ? dat_q  : '0;

endmodule

// File: tb/tb_spr_initiator.sv
// Directed bench for spr_initiator: transfers queue expected responses, a monitor checks each pulse.
module tb_spr_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic        req_we_i;
  logic [15:0] req_addr_i;
  logic [31:0] req_dat_i;
  logic        req_ready_o;
  logic        rsp_valid_o;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        flush_i;
  logic        spr_access_o;
  logic        spr_we_o;
  logic [15:0] spr_addr_o;
  logic [31:0] spr_dat_o;
  logic        spr_bus_ack_i;
  logic [31:0] spr_dat_i;

  spr_initiator #(.OPTION_SPR_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_dat_i(req_dat_i),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .flush_i(flush_i),
    .spr_access_o(spr_access_o), .spr_we_o(spr_we_o), .spr_addr_o(spr_addr_o),
    .spr_dat_o(spr_dat_o), .spr_bus_ack_i(spr_bus_ack_i), .spr_dat_i(spr_dat_i)
  );

  always #5 clk = ~clk;

  // Responder: acc_cnt is the index of the current ACCESS cycle (0 on the first one).
  int          acc_cnt = 0;
  int          ack_delay = -1;
  int          flush_at = -1;
  logic [31:0] rd_data = '0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) acc_cnt <= 0;
    else        acc_cnt <= spr_access_o ? acc_cnt + 1 : 0;

  assign spr_bus_ack_i = spr_access_o && (ack_delay >= 0) && (acc_cnt == ack_delay);
  assign flush_i       = spr_access_o && (flush_at >= 0) && (acc_cnt == flush_at);
  assign spr_dat_i     = spr_bus_ack_i ? rd_data : 32'hDEAD_BEEF;

  int nvec = 0;
  int nfail = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        nvec++; nfail++;
        $display("FAIL unexpected_rsp: got dat=0x%0h err=%0b expected no response at %0t",
                 rsp_dat_o, rsp_err_o, $time);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_dat_err", {31'b0, rsp_dat_o, rsp_err_o}, {31'b0, e});
      end
    end
  end

  // Called just after a rising edge with the DUT idle.
  task automatic xfer(input bit we, input logic [15:0] a, input logic [31:0] d,
                      input int ackd, input int fl, input logic [31:0] rdat,
                      input int exp_len, input bit exp_rsp, input bit exp_err);
    int n;
    logic [31:0] exp_dat;
    ack_delay = ackd; flush_at = fl; rd_data = rdat;
    req_i = 1'b1; req_we_i = we; req_addr_i = a; req_dat_i = d;
    exp_dat = (we || exp_err) ? 32'h0 : rdat;
    @(negedge clk);
    chk("ready_idle", {63'b0, req_ready_o}, 64'd1);
    if (exp_rsp) exp_q.push_back({exp_dat, exp_err});
    @(posedge clk); #1;
    req_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_dat_i = '0;
    n = 0;
    while (spr_access_o && n < 300) begin
      @(negedge clk);
      chk("bus_fields", {15'b0, spr_we_o, spr_addr_o, spr_dat_o}, {15'b0, we, a, d});
      chk("ready_busy", {63'b0, req_ready_o}, 64'd0);
      n++;
      @(posedge clk); #1;
    end
    chk("access_len", 64'(n), 64'(exp_len));
    if (exp_rsp) begin @(posedge clk); #1; end
    chk("idle_after", {63'b0, req_ready_o}, 64'd1);
    chk("bus_idle", {15'b0, spr_we_o, spr_addr_o, spr_dat_o}, 64'd0);
    if (exp_rsp) chk("rsp_hold", {31'b0, rsp_dat_o, rsp_err_o}, {31'b0, exp_dat, exp_err});
    ack_delay = -1; flush_at = -1;
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, last, nlow, n;
    rst_n = 1'b0; req_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_dat_i = '0;
    #1;
    chk("reset_state", {58'b0, req_ready_o, spr_access_o, rsp_valid_o, rsp_err_o, spr_we_o, |rsp_dat_o},
        {58'b0, 6'b100000});
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // write, combinational ack
    xfer(1'b1, 16'h4800, 32'h0000_00F0, 0, -1, 32'h0, 1, 1, 0);
    // read, ack on 4th ACCESS cycle
    xfer(1'b0, 16'h4802, 32'h0, 3, -1, 32'h0000_0005, 4, 1, 0);
    // read, never acked -> timeout
    xfer(1'b0, 16'h4803, 32'h0, -1, -1, 32'h0, 16, 1, 1);
    // flush on 2nd ACCESS cycle, no ack
    xfer(1'b0, 16'h0011, 32'h0, -1, 1, 32'h0, 2, 0, 0);
    // flush together with ack
    xfer(1'b0, 16'h0012, 32'h0, 1, 1, 32'hA5A5_5A5A, 2, 1, 0);
    // ack on the timeout cycle wins
    xfer(1'b0, 16'h0013, 32'h0, 15, -1, 32'h0000_0077, 16, 1, 0);

    // three back-to-back reads with req_i held high
    ack_delay = 0; rd_data = 32'h0000_1234;
    req_i = 1'b1; req_we_i = 1'b0; req_addr_i = 16'h0020;
    repeat (3) exp_q.push_back({32'h0000_1234, 1'b0});
    acc = 0; last = 0; nlow = 0;
    for (int c = 0; c < 20 && acc < 3; c++) begin
      @(negedge clk);
      if (req_ready_o) begin
        if (acc > 0) chk("b2b_spacing", 64'(c - last), 64'd3);
        last = c; acc++;
      end else nlow++;
      @(posedge clk); #1;
    end
    req_i = 1'b0;
    chk("b2b_accepts", 64'(acc), 64'd3);
    chk("b2b_ready_low", 64'(nlow), 64'd4);
    repeat (4) @(posedge clk);
    #1;
    ack_delay = -1;

    // reset asserted mid-ACCESS
    req_i = 1'b1; req_we_i = 1'b0; req_addr_i = 16'h0030;
    @(posedge clk); #1;
    req_i = 1'b0;
    n = 0;
    while (!spr_access_o && n < 5) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk);
    #2;
    chk("pre_reset_access", {63'b0, spr_access_o}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_access", {60'b0, spr_access_o, req_ready_o, rsp_valid_o, |{rsp_dat_o, rsp_err_o}},
        {60'b0, 4'b0100});
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
